// File: rtl/seg_display_sched_if.sv
// rtl/seg_display_sched_if.sv - requester/display bus for the seven-segment scheduler
interface seg_display_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [7:0]         sseg_an;
  logic [7:0]         sseg_ca;

  modport master (
    output req, data,
    input  gnt, busy, sseg_an, sseg_ca
  );

  modport slave (
    input  req, data,
    output gnt, busy, sseg_an, sseg_ca
  );
endinterface

// File: rtl/seg_display_sched.sv
// rtl/seg_display_sched.sv - round-robin owner of the multiplexed 8-digit hex display
// Owns digit scan timing and hex decode; one blank slot separates owners.
module seg_display_sched #(
  parameter int NREQ        = 4,
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_display_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [2:0]    DIG_LAST = 3'(DIGITS - 1);
  localparam logic [FW:0]   HOLD_W   = (FW+1)'(HOLD_FRAMES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, SHOW, SWITCH} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [2:0]      digit;
  logic [DW-1:0]   div_cnt;
  logic [FW-1:0]   frame_cnt;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            upd;
  logic [7:0]      an_q;
  logic [7:0]      ca_q;

  logic            tick;
  logic            frame_end;
  logic            own_req;
  logic            hold_done;
  logic [NREQ-1:0] own_mask;
  logic [NREQ-1:0] others;
  logic [FW:0]     fc_inc;
  logic [FW-1:0]   fc_sat;
  logic [IW:0]     idle_pick;
  logic [IW:0]     sw_pick;
  logic [IW+4:0]   nib_sel;
  logic [3:0]      nib;

  // index increment modulo NREQ
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return NREQ'(1) << i;
  endfunction

  // first set request at/after start, wrapping; returns {found, index}
  function automatic logic [IW:0] pick(input logic [IW-1:0] start, input logic [NREQ-1:0] r);
    logic            found;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   cur;
    logic [NREQ-1:0] rot;
    found = 1'b0;
    idx   = '0;
    cur   = start;
    for (int k = 0; k < NREQ; k++) begin
      rot = r >> cur;
      if (!found && rot[0]) begin
        found = 1'b1;
        idx   = cur;
      end
      cur = wrap_inc(cur);
    end
    return {found, idx};
  endfunction

  // active-low segments {dp,g..a}; dp stays off
  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h98;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      4'hF: return 8'h8E;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign frame_end = tick && (digit == DIG_LAST);
  assign own_mask  = onehot(owner);
  assign others    = bus.req & ~own_mask;
  assign own_req   = |(bus.req & own_mask);
  assign fc_inc    = {1'b0, frame_cnt} + 1'b1;
  assign hold_done = (fc_inc >= HOLD_W);
  assign fc_sat    = hold_done ? HOLD_W[FW-1:0] : fc_inc[FW-1:0];
  assign idle_pick = pick(rr_ptr, bus.req);
  assign sw_pick   = pick(wrap_inc(owner), bus.req);
  // live nibble of the owner's current digit; only captured on update edges
  assign nib_sel   = {owner, digit, 2'b00};
  assign nib       = bus.data[nib_sel +: 4];

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.sseg_an = an_q;
  assign bus.sseg_ca = ca_q;

  // arbitration FSM, slot timer and display registers; outputs refresh the cycle after upd
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      digit     <= '0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      upd       <= 1'b0;
      an_q      <= 8'hFF;
      ca_q      <= 8'hFF;
    end else begin
      upd <= 1'b0;
      if (upd) begin
        if (state == SHOW) begin
          an_q <= ~(8'd1 << digit);
          ca_q <= decode(nib);
        end else begin
          an_q <= 8'hFF;
          ca_q <= 8'hFF;
        end
      end
      case (state)
        IDLE: begin
          if (idle_pick[IW]) begin
            owner     <= idle_pick[IW-1:0];
            gnt_q     <= onehot(idle_pick[IW-1:0]);
            busy_q    <= 1'b1;
            state     <= SHOW;
            digit     <= '0;
            frame_cnt <= '0;
            div_cnt   <= '0;
            upd       <= 1'b1;
          end
        end
        SHOW: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            upd <= 1'b1;
            if (frame_end) begin
              digit     <= '0;
              frame_cnt <= fc_sat;
              if (!own_req) begin
                gnt_q <= '0;
                if (|others) begin
                  state <= SWITCH;
                end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  rr_ptr <= wrap_inc(owner);
                end
              end else if (hold_done && (|others)) begin
                gnt_q <= '0;
                state <= SWITCH;
              end
            end else begin
              digit <= digit + 1'b1;
            end
          end
        end
        SWITCH: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            upd <= 1'b1;
            if (sw_pick[IW]) begin
              owner     <= sw_pick[IW-1:0];
              gnt_q     <= onehot(sw_pick[IW-1:0]);
              rr_ptr    <= wrap_inc(sw_pick[IW-1:0]);
              state     <= SHOW;
              digit     <= '0;
              frame_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_sched.sv
// tb/tb_seg_display_sched.sv - scoreboard bench for seg_display_sched
module tb_seg_display_sched;

  localparam int NREQ     = 4;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 2;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [7:0] an;
    logic [7:0] ca;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [31:0] words [4] = '{32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h02468ACE};
  logic [7:0]  seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  seg_display_sched_if #(.NREQ(NREQ)) sif ();

  seg_display_sched #(
    .NREQ(NREQ), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(sif)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic b, input logic [7:0] a, input logic [7:0] c);
    exp_t e;
    e.gnt = g; e.busy = b; e.an = a; e.ca = c;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_gnt"},  sif.gnt,     e.gnt);
      chk({tag, "_busy"}, sif.busy,    e.busy);
      chk({tag, "_an"},   sif.sseg_an, e.an);
      chk({tag, "_ca"},   sif.sseg_ca, e.ca);
    end
  endtask

  // called 1ns after the edge that enters SHOW; samples each digit mid-slot
  task automatic show_session(input int own, input int frames, input int chg_slot, input logic [3:0] chg_req);
    logic [3:0] g;
    logic [7:0] a;
    logic [3:0] n;
    g = 4'b0001 << own;
    push(g, 1'b1, 8'hFF, 8'hFF);
    for (int f = 0; f < frames; f++) begin
      for (int d = 0; d < DIGITS; d++) begin
        a = ~(8'h01 << d);
        n = words[own][d*4 +: 4];
        push(g, 1'b1, a, seg_lut[n]);
      end
    end
    check_sb($sformatf("own%0d_entry", own));
    for (int s = 0; s < frames * DIGITS; s++) begin
      step((s == 0) ? 2 : 4);
      check_sb($sformatf("own%0d_slot%0d", own, s));
      if (s == chg_slot) sif.req = chg_req;
    end
  endtask

  task automatic blank_slot(input string tag);
    step(2);
    chk({tag, "_sw_gnt"},  sif.gnt,  4'b0000);
    chk({tag, "_sw_busy"}, sif.busy, 1'b1);
    step(1);
    chk({tag, "_sw_an"},   sif.sseg_an, 8'hFF);
    chk({tag, "_sw_ca"},   sif.sseg_ca, 8'hFF);
    step(2);
    chk({tag, "_sw_an_late"},  sif.sseg_an, 8'hFF);
    chk({tag, "_sw_gnt_late"}, sif.gnt,     4'b0000);
    step(1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    sif.req = 4'b0000;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    sif.req  = 4'hF;
    sif.data = {words[3], words[2], words[1], words[0]};

    // reset held with all requests high
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("rst%0d_gnt", i),  sif.gnt,     4'b0000);
      chk($sformatf("rst%0d_an", i),   sif.sseg_an, 8'hFF);
      chk($sformatf("rst%0d_ca", i),   sif.sseg_ca, 8'hFF);
      chk($sformatf("rst%0d_busy", i), sif.busy,    1'b0);
    end

    // single requester, repeats past the hold period
    rst_n   = 1'b1;
    sif.req = 4'b0001;
    step(1);
    show_session(0, 3, -1, 4'b0000);

    // full rotation
    do_reset();
    sif.req = 4'hF;
    step(1);
    show_session(0, 2, -1, 4'b0000);
    blank_slot("rot01");
    show_session(1, 2, -1, 4'b0000);
    blank_slot("rot12");
    show_session(2, 2, -1, 4'b0000);
    blank_slot("rot23");
    show_session(3, 2, -1, 4'b0000);
    blank_slot("rot30");
    show_session(0, 1, -1, 4'b0000);

    // owner drops exactly as hold expires while req[3] waits
    do_reset();
    sif.req = 4'b0001;
    step(1);
    show_session(0, 2, 2*DIGITS-1, 4'b1000);
    blank_slot("simul");
    show_session(3, 1, -1, 4'b0000);

    // owner 2 releases mid-frame with nobody else waiting
    do_reset();
    sif.req = 4'b0100;
    step(1);
    show_session(2, 1, 2, 4'b0000);
    step(2);
    chk("rel_gnt",  sif.gnt,  4'b0000);
    chk("rel_busy", sif.busy, 1'b0);
    step(1);
    chk("rel_an", sif.sseg_an, 8'hFF);
    chk("rel_ca", sif.sseg_ca, 8'hFF);
    step(5);
    chk("idle_an",   sif.sseg_an, 8'hFF);
    chk("idle_busy", sif.busy,    1'b0);
    sif.req = 4'b0011;
    step(1);
    chk("wrap_gnt",  sif.gnt,  4'b0001);
    chk("wrap_busy", sif.busy, 1'b1);

    // reset in the middle of digit 5
    step(21);
    chk("mid_an", sif.sseg_an, 8'hDF);
    chk("mid_ca", sif.sseg_ca, seg_lut[words[0][23:20]]);
    rst_n   = 1'b0;
    sif.req = 4'b1010;
    step(1);
    chk("midrst_gnt",  sif.gnt,     4'b0000);
    chk("midrst_busy", sif.busy,    1'b0);
    chk("midrst_an",   sif.sseg_an, 8'hFF);
    chk("midrst_ca",   sif.sseg_ca, 8'hFF);
    rst_n = 1'b1;
    step(1);
    chk("restart_gnt", sif.gnt, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
